// File: rtl/cruise_pkg.sv
// cruise_pkg: shared ALU mode codes, FSM/phase encodings and default limits for the cruise controller.
package cruise_pkg;
    localparam logic [1:0] MODE_INC  = 2'd0;
    localparam logic [1:0] MODE_DEC  = 2'd1;
    localparam logic [1:0] MODE_PASS = 2'd2;
    localparam logic [1:0] MODE_CMP  = 2'd3;
    localparam int DEF_MIN_CRUISE = 45;
    localparam int DEF_MAX_SPEED  = 200;
    typedef enum logic [1:0] {ST_OFF = 2'd0, ST_CRUISE = 2'd1, ST_ACCEL = 2'd2} state_t;
    typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_CMP = 2'd1, PH_UPD = 2'd2} phase_t;
    function automatic logic [7:0] clamp_speed(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction
endpackage

// File: rtl/cruise_controller_tick_gen.sv
// tick_gen: free-running modulo-TICK_DIV counter; tick is high in the last count of each period.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign tick = (cnt_q == LAST);
endmodule

// File: rtl/cruise_controller.sv
// cruise_controller: owns speed/set-point registers and sequences the external ALU
// through a CMP then UPD cycle after every speed tick.
module cruise_controller import cruise_pkg::*; #(
    parameter int TICK_DIV   = 4,
    parameter int MIN_CRUISE = DEF_MIN_CRUISE,
    parameter int MAX_SPEED  = DEF_MAX_SPEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cruise_on,
    input  logic       cruise_off,
    input  logic       accel,
    input  logic       brake,
    input  logic       speed_load,
    input  logic [7:0] speed_in,
    input  logic [7:0] alu_result,
    input  logic       alu_g,
    input  logic       alu_eq,
    input  logic       alu_l,
    output logic [1:0] alu_mode,
    output logic [7:0] alu_current,
    output logic [7:0] alu_default,
    output logic [7:0] speed,
    output logic [7:0] set_speed,
    output logic       cruise_active,
    output logic [1:0] state
);
    localparam logic [7:0] MIN_C = 8'(MIN_CRUISE);
    localparam logic [7:0] MAX_S = 8'(MAX_SPEED);

    logic       tick, stop;
    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [1:0] mode_q, mode_d, want_mode, upd_mode;
    logic [7:0] speed_q, speed_d, set_speed_q, set_speed_d;
    logic       active_q, active_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));

    always_ff @(posedge clk)
        if (reset) begin
            state_q     <= ST_OFF;
            phase_q     <= PH_IDLE;
            mode_q      <= MODE_PASS;
            speed_q     <= '0;
            set_speed_q <= '0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            set_speed_q <= set_speed_d;
            active_q    <= active_d;
        end

    always_comb begin
        stop = brake | cruise_off;
        case (state_q)
            ST_OFF:    state_d = (cruise_on && !stop && speed_q >= MIN_C) ? ST_CRUISE : ST_OFF;
            ST_CRUISE: state_d = stop ? ST_OFF : accel ? ST_ACCEL : ST_CRUISE;
            ST_ACCEL:  state_d = stop ? ST_OFF : accel ? ST_ACCEL : ST_CRUISE;
            default:   state_d = ST_OFF;
        endcase
    end

    // The UPD mode is chosen during CMP (flags valid, next state known) and registered.
    always_comb begin
        phase_d = tick ? PH_CMP : (phase_q == PH_CMP) ? PH_UPD : PH_IDLE;
        speed_d = speed_load ? clamp_speed(speed_in, MAX_S) : (phase_q == PH_UPD) ? alu_result : speed_q;
        set_speed_d = (state_d == ST_CRUISE && state_q != ST_CRUISE) ? speed_q :
                      (state_q == ST_ACCEL && state_d == ST_ACCEL && phase_q == PH_UPD) ? speed_d :
                      set_speed_q;
        want_mode = (state_d == ST_ACCEL) ? MODE_INC :
                    (state_d == ST_CRUISE) ? (alu_eq ? MODE_PASS : alu_g ? MODE_DEC : alu_l ? MODE_INC : MODE_PASS) :
                    (accel ? MODE_INC : MODE_DEC);
        upd_mode = ((want_mode == MODE_INC && speed_d == MAX_S) ||
                    (want_mode == MODE_DEC && speed_d == 8'd0)) ? MODE_PASS : want_mode;
        mode_d = (phase_d == PH_CMP) ? MODE_CMP : (phase_d == PH_UPD) ? upd_mode : MODE_PASS;
        active_d = (state_d != ST_OFF);
    end

    assign alu_mode      = mode_q;
    assign alu_current   = speed_q;
    assign alu_default   = set_speed_q;
    assign speed         = speed_q;
    assign set_speed     = set_speed_q;
    assign cruise_active = active_q;
    assign state         = state_q;
endmodule

// File: doc/cruise_controller.md
# cruise_controller

Sequencing controller for the cruise-control `ALU`. It owns the vehicle speed register and the cruise set-point register. On every speed tick it drives the ALU through a compare cycle and then an update cycle, and it writes the ALU result back into the speed register. It sits between the driver inputs (cruise on/off, accelerator, brake, speed-sensor override) and the combinational `ALU`, which has no state of its own.

## Interface
Parameters:
- `TICK_DIV`, 4: clock cycles per speed tick; legal range is 3 or more.
- `MIN_CRUISE`, 45: minimum speed at which cruise may engage.
- `MAX_SPEED`, 200: the speed register saturates at this value.

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `cruise_on`  in  1  engage request (level-sampled).
- `cruise_off`  in  1  disengage request.
- `accel`  in  1  accelerator pedal.
- `brake`  in  1  brake pedal; highest priority.
- `speed_load`  in  1  sensor override strobe.
- `speed_in`  in  8  speed value written on `speed_load`.
- `alu_result`  in  8  ALU result.
- `alu_g`, `alu_eq`, `alu_l`  in  1 each  ALU compare flags (current vs default).
- `alu_mode`  out  2  ALU operation select.
- `alu_current`  out  8  connected to the ALU `current_speed` input; equals `speed`.
- `alu_default`  out  8  connected to the ALU `default_speed` input; equals `set_speed`.
- `speed`  out  8  speed register.
- `set_speed`  out  8  cruise set-point.
- `cruise_active`  out  1  high in the CRUISE and ACCEL states.
- `state`  out  2  FSM state, for debug.

## Operation
ALU mode encoding:
- 0 = INC: result = current + 1.
- 1 = DEC: result = current - 1.
- 2 = PASS: result = current.
- 3 = CMP: result = current; flags are valid.

FSM states, with encoding: OFF=0, CRUISE=1, ACCEL=2.

Transitions (brake and cruise_off always take precedence):
- OFF -> CRUISE when `cruise_on` is high, `brake` is low and `speed` ≥ MIN_CRUISE. `set_speed` is loaded with `speed` on the same edge. `cruise_on` below MIN_CRUISE is ignored.
- CRUISE -> ACCEL when `accel` is high.
- ACCEL -> CRUISE when `accel` is low. `set_speed` is loaded with `speed` on the same edge.
- CRUISE or ACCEL -> OFF when `brake` or `cruise_off` is high. This applies in any cycle, including mid-sequence.

Update decision, made in the UPD cycle from the current state:
- OFF: `accel` → INC; otherwise DEC (brake or coast).
- CRUISE: `alu_g` → DEC, `alu_l` → INC, `alu_eq` → PASS. The flags are registered at the end of the CMP cycle.
- ACCEL: INC. `set_speed` follows the new speed on the same edge.

Saturation:
- INC is replaced by PASS when `speed` == MAX_SPEED.
- DEC is replaced by PASS when `speed` == 0.
- The 8-bit ALU therefore never wraps.

Write-back: `speed` is loaded with `alu_result` at the end of the UPD cycle.

`speed_load`:
- Writes `speed_in` in any cycle.
- If it coincides with a UPD write-back, it wins over the write-back.
- `speed_in` above MAX_SPEED is clamped to MAX_SPEED.

## Timing
Reset values:
- `speed`=0, `set_speed`=0, `state`=OFF, `cruise_active`=0.
- Tick counter = 0, phase = IDLE.
- `alu_mode`=2 (PASS).

Tick and phase sequence:
- The tick counter counts 0..TICK_DIV-1. The tick is the cycle in which the count equals TICK_DIV-1.
- Tick in cycle T → phase CMP in T+1 (`alu_mode`=3) → phase UPD in T+2 (`alu_mode`=0/1/2) → the new `speed` is visible in T+3.
- In all other cycles phase is IDLE and `alu_mode`=2.
- `alu_mode`, `state`, `cruise_active` and the phase are all driven from flops; there is no combinational path from the pedal inputs to `alu_mode`.

Event timing:
- State transitions take effect on the edge after the input is sampled.
- A brake sampled in cycle T+1 makes the UPD cycle in T+2 use the OFF rule (DEC).
- `reset` asserted mid-sequence aborts it; the next cycle shows the reset values.

## Structure
Shared package `cruise_pkg`:
- ALU mode constants `MODE_INC`, `MODE_DEC`, `MODE_PASS`, `MODE_CMP`.
- FSM state constants.
- Default values for MIN_CRUISE and MAX_SPEED.

One sub-module, `tick_gen`: the TICK_DIV counter, producing a one-cycle `tick` pulse. The ALU is instantiated next to this block at top level, not inside it.

## Test plan
With TICK_DIV=4 and the real `ALU` connected:
1. Reset → all outputs 0, `alu_mode`=2; the first CMP cycle is cycle 4 after reset release.
2. OFF, `accel` held for 10 ticks from speed 0 → `speed`=10. Release for 3 ticks → `speed`=7. Coast from 1 → 0, then stays at 0.
3. `speed_load` 50, then `cruise_on` → `cruise_active`=1 and `set_speed`=50. `speed_load` 54 → `speed` returns to 50 after 4 ticks and holds there with PASS.
4. Cruising at 60, `accel` for 5 ticks → `state`=ACCEL and `speed`=65. Release → CRUISE with `set_speed`=65.
5. `brake` asserted during a CMP cycle while cruising at 60 → `state`=OFF next cycle, `cruise_active`=0, and that UPD decrements to 59.
6. `cruise_on` at speed 40 is ignored (stays OFF). `speed_load` 250 → 200. `accel` held at 200 → `speed` stays at 200.
